// File: rtl/sha3_state_feeder.sv
// -----------------------------------------------------------------------------
// sha3_state_feeder
//
// Transmit-side serializer in front of the SHA3 permutation engine. Accepts a
// complete Keccak state (NBEATS*BEAT_W bits) over a valid/ready handshake and
// replays it as NBEATS registered beats on the pushin/dix/din protocol used by
// the permutation engine's input stage. A one-state holding buffer lets the
// next state queue up behind the one being emitted, so consecutive states
// leave back to back with no idle cycle.
//
// Ports
//   clk        : clock, all flops on the rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : a state is offered on in_state
//   in_ready   : feeder can take a state (holding buffer empty)
//   in_state   : flattened state, bit 0 = lane (0,0) bit 0
//   en         : beat enable; low pauses emission without losing position
//   pushin     : beat valid (registered)
//   dix        : beat index 0..NBEATS-1 (registered)
//   din        : beat data, beat k = in_state[k*BEAT_W +: BEAT_W] (registered)
//   busy       : active register or holding buffer holds a state
//   sent_count : number of fully emitted states, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module sha3_state_feeder #(
    parameter  int unsigned BEAT_W  = 200,
    parameter  int unsigned NBEATS  = 8,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W   = $clog2(NBEATS),
    localparam int unsigned STATE_W = BEAT_W * NBEATS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               en,
    output logic               pushin,
    output logic [IDX_W-1:0]   dix,
    output logic [BEAT_W-1:0]  din,
    output logic               busy,
    output logic [CNT_W-1:0]   sent_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    state_e                        state_q;
    logic [IDX_W-1:0]              bcnt_q;
    // Stored as an array of beats so the beat mux is a plain index.
    logic [NBEATS-1:0][BEAT_W-1:0] act_q;
    logic [NBEATS-1:0][BEAT_W-1:0] buf_q;
    logic                          buf_full_q;
    logic                          pushin_q;
    logic [IDX_W-1:0]              dix_q;
    logic [BEAT_W-1:0]             din_q;
    logic [CNT_W-1:0]              cnt_q;

    logic accept;

    // The buffer is the only thing that can refuse a state: when it is empty
    // either the active register is free or the buffer can absorb the state.
    assign in_ready = ~buf_full_q;
    assign accept   = in_valid & ~buf_full_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            act_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pushin_q   <= 1'b0;
            dix_q      <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
        end else begin
            pushin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        act_q   <= in_state;
                        bcnt_q  <= '0;
                        state_q <= SEND;
                    end
                end

                SEND: begin
                    if (en) begin
                        pushin_q <= 1'b1;
                        dix_q    <= bcnt_q;
                        din_q    <= act_q[bcnt_q];
                        if (bcnt_q == LAST_IDX) begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            bcnt_q <= '0;
                            // Refill the active register from the buffer first;
                            // a full buffer implies no accept can be happening.
                            // With the buffer empty, a state accepted on this
                            // very edge bypasses the buffer to avoid a bubble.
                            if (buf_full_q) begin
                                act_q      <= buf_q;
                                buf_full_q <= 1'b0;
                            end else if (accept) begin
                                act_q <= in_state;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bcnt_q <= bcnt_q + IDX_W'(1);
                            if (accept) begin
                                buf_q      <= in_state;
                                buf_full_q <= 1'b1;
                            end
                        end
                    end else if (accept) begin
                        // Paused: beat position and outputs hold.
                        buf_q      <= in_state;
                        buf_full_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign pushin     = pushin_q;
    assign dix        = dix_q;
    assign din        = din_q;
    assign busy       = (state_q == SEND) | buf_full_q;
    assign sent_count = cnt_q;

endmodule
